ysyx_22040759_rd_arbiter_rr: RTL and testbench

//  N-master read-channel arbiter. Sits between IF, MEM and other read requesters and the single AXI read

---
 rtl/ysyx_22040759_rd_arbiter_rr.sv | 173 +++++++++++++++++
 tb/tb_ysyx_22040759_rd_arbiter_rr.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040759_rd_arbiter_rr.sv
// ysyx_22040759_rd_arbiter_rr
// N-master read-channel arbiter in front of a single AXI read bridge port.
// One read is outstanding at a time. The granted master keeps the bridge until
// its response returns or it withdraws its request. A response always costs one
// idle cycle before the next grant, so a master's stale valid is never re-granted.
//
// Build option:
//   YSYX_ARB_FIXED_PRIO_EN  defined     -> fixed priority (lowest index wins),
//                                          rr_ptr held at 0
//                           not defined -> round-robin starting at master 0
module ysyx_22040759_rd_arbiter_rr #(
    parameter int NUM_MST = 3,
    parameter int AW      = 64,
    parameter int DW      = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MST-1:0]     m_req_valid_i,
    input  logic [NUM_MST*AW-1:0]  m_req_addr_i,
    input  logic [NUM_MST*2-1:0]   m_req_size_i,
    output logic [NUM_MST-1:0]     m_rsp_valid_o,
    output logic [DW-1:0]          m_rsp_data_o,
    output logic [NUM_MST-1:0]     m_grant_o,
    output logic                   s_req_valid_o,
    output logic [AW-1:0]          s_req_addr_o,
    output logic [1:0]             s_req_size_o,
    input  logic                   s_rsp_valid_i,
    input  logic [DW-1:0]          s_rsp_data_i
);

    // Pointer width; a non-power-of-2 master count wraps explicitly below.
    localparam int              PW       = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam logic [PW-1:0]   LAST_IDX = PW'(NUM_MST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NUM_MST-1:0]  grant;
    logic [NUM_MST-1:0]  grant_nxt;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       win_idx;
    logic                req_any;
    logic                owner_valid;
    logic                busy;

    assign req_any     = |m_req_valid_i;
    assign owner_valid = |(grant & m_req_valid_i);
    assign busy        = (state == BUSY);

`ifdef YSYX_ARB_FIXED_PRIO_EN

    // Fixed priority: scan from the top down so the lowest valid index is the last write.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        win_idx = '0;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            if (m_req_valid_i[i]) begin
                win_idx = PW'(i);
            end
        end
    end

    assign rr_ptr = '0;

`else

    // Add an offset to a master index, wrapping at NUM_MST (not at 2**PW).
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        logic [PW:0] sum;
        sum = {1'b0, base} + (PW+1)'(off);
        if (sum >= (PW+1)'(NUM_MST)) begin
            sum = sum - (PW+1)'(NUM_MST);
        end
        return sum[PW-1:0];
    endfunction

    // Round-robin: search upward from rr_ptr, first valid master wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        logic found;
        found   = 1'b0;
        win_idx = '0;
        for (int off = 0; off < NUM_MST; off++) begin
            if (!found && m_req_valid_i[wrap_add(rr_ptr, off)]) begin
                found   = 1'b1;
                win_idx = wrap_add(rr_ptr, off);
            end
        end
    end

    // Pointer moves past the winner on every grant; aborts leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (!busy && req_any) begin
            rr_ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
        end
    end

`endif

    // State and grant registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of block ordering.
        if (rst) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    // Next state: grant on request in IDLE, release on response or withdrawn request.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = BUSY;
                    grant_nxt = NUM_MST'(1) << win_idx;
                end
            end
            BUSY: begin
                // Response and abort both return to IDLE; only a response strobes a master.
                if (s_rsp_valid_i || !owner_valid) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Address/size mux from the granted master; all zero while idle since grant is zero.
    always_comb begin
        s_req_addr_o = '0;
        s_req_size_o = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (grant[i]) begin
                s_req_addr_o = s_req_addr_o | m_req_addr_i[i*AW +: AW];
                s_req_size_o = s_req_size_o | m_req_size_i[i*2 +: 2];
            end
        end
    end

    assign s_req_valid_o = busy && owner_valid;
    assign m_rsp_valid_o = grant & {NUM_MST{s_rsp_valid_i && busy}};
    assign m_rsp_data_o  = s_rsp_data_i;
    assign m_grant_o     = grant;

`ifndef SYNTHESIS
    // Grant is one-hot or zero, and only a busy arbiter holds a grant.
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant) && (busy || grant == '0));

    // A response strobe reaches at most one master.
    a_rsp_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(m_rsp_valid_o));
`endif

endmodule

// File: tb/tb_ysyx_22040759_rd_arbiter_rr.sv
// Testbench for ysyx_22040759_rd_arbiter_rr (NUM_MST=3).
// Directed cycle table, a round-robin fairness sequence, then randomized
// traffic checked against a transaction-level reference model.
module tb_ysyx_22040759_rd_arbiter_rr;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    vld;
    logic [63:0]     addr_a [N];
    logic [1:0]      size_a [N];
    logic            rsp;
    logic [63:0]     rsp_data;

    logic [N*64-1:0] req_addr;
    logic [N*2-1:0]  req_size;
    logic [N-1:0]    m_rsp_valid;
    logic [63:0]     m_rsp_data;
    logic [N-1:0]    m_grant;
    logic            s_req_valid;
    logic [63:0]     s_req_addr;
    logic [1:0]      s_req_size;

    int errors = 0;
    int checks = 0;

    assign req_addr = {addr_a[2], addr_a[1], addr_a[0]};
    assign req_size = {size_a[2], size_a[1], size_a[0]};

    ysyx_22040759_rd_arbiter_rr #(.NUM_MST(N), .AW(64), .DW(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .m_req_valid_i (vld),
        .m_req_addr_i  (req_addr),
        .m_req_size_i  (req_size),
        .m_rsp_valid_o (m_rsp_valid),
        .m_rsp_data_o  (m_rsp_data),
        .m_grant_o     (m_grant),
        .s_req_valid_o (s_req_valid),
        .s_req_addr_o  (s_req_addr),
        .s_req_size_o  (s_req_size),
        .s_rsp_valid_i (rsp),
        .s_rsp_data_i  (rsp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] v, input logic s, input logic [63:0] d);
        rst      = r;
        vld      = v;
        rsp      = s;
        rsp_data = d;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int k = 0; k < N; k++) begin
            if (g == (N'(1) << k)) return k;
        end
        return -1;
    endfunction

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic          r;
        logic [N-1:0]  v;
        logic          s;
        logic [63:0]   d;
        logic [N-1:0]  exp_grant;
        logic          exp_sreq;
        logic [N-1:0]  exp_rsp;
    } row_t;

    row_t tbl[$];

    task automatic add(input logic r, input logic [N-1:0] v, input logic s, input logic [63:0] d,
                       input logic [N-1:0] eg, input logic es, input logic [N-1:0] er);
        row_t row;
        row = '{r, v, s, d, eg, es, er};
        tbl.push_back(row);
    endtask

    function automatic logic [63:0] sel_addr(input logic [N-1:0] g);
        int k;
        k = onehot_idx(g);
        return (k < 0) ? 64'h0 : addr_a[k];
    endfunction

    function automatic logic [1:0] sel_size(input logic [N-1:0] g);
        int k;
        k = onehot_idx(g);
        return (k < 0) ? 2'b00 : size_a[k];
    endfunction

`ifdef YSYX_ARB_FIXED_PRIO_EN
    localparam logic [N-1:0] AFTER_ABORT = 3'b001;
    localparam int FAIR_ORDER [6] = '{0, 0, 0, 0, 0, 0};
`else
    localparam logic [N-1:0] AFTER_ABORT = 3'b100;
    localparam int FAIR_ORDER [6] = '{0, 1, 2, 0, 1, 2};
`endif

    // ---------------- reference model ----------------
    bit mdl_busy;
    int mdl_owner;
    int mdl_ptr;

    function automatic int mdl_pick(input logic [N-1:0] v);
`ifdef YSYX_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
`else
        for (int k = 0; k < N; k++) begin
            int j;
            j = (mdl_ptr + k) % N;
            if (v[j]) return j;
        end
`endif
        return -1;
    endfunction

    task automatic mdl_advance(input logic r, input logic [N-1:0] v, input logic s);
        if (r) begin
            mdl_busy = 0;
            mdl_ptr  = 0;
        end else if (!mdl_busy) begin
            if (v != '0) begin
                mdl_owner = mdl_pick(v);
                mdl_busy  = 1;
                mdl_ptr   = (mdl_owner + 1) % N;
            end
        end else if (s || !v[mdl_owner]) begin
            mdl_busy = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int held;
        int order[$];
        logic [N-1:0] eg;
        logic         s;

        addr_a[0] = 64'h0000_0000_1000_0000; size_a[0] = 2'b00;
        addr_a[1] = 64'h0000_0000_8000_0010; size_a[1] = 2'b11;
        addr_a[2] = 64'h0000_0000_2000_0020; size_a[2] = 2'b10;
        drive(1'b1, '0, 1'b0, 64'h0);

        // reset with every master requesting
        add(1, 3'b111, 0, 64'h0,         3'b000, 0, 3'b000);
        add(1, 3'b111, 0, 64'h0,         3'b000, 0, 3'b000);
        add(0, 3'b111, 0, 64'h0,         3'b000, 0, 3'b000);
        add(0, 3'b111, 0, 64'h0,         3'b001, 1, 3'b000);
        add(0, 3'b111, 1, 64'h11,        3'b001, 1, 3'b001);
        add(0, 3'b000, 0, 64'h0,         3'b000, 0, 3'b000);
        // single request from master 1
        add(0, 3'b010, 0, 64'h0,         3'b000, 0, 3'b000);
        add(0, 3'b010, 0, 64'h0,         3'b010, 1, 3'b000);
        add(0, 3'b010, 1, 64'hDEAD_BEEF, 3'b010, 1, 3'b010);
        add(0, 3'b000, 0, 64'h0,         3'b000, 0, 3'b000);
        // no preemption: master 0 arrives while master 2 owns the bridge
        add(0, 3'b100, 0, 64'h0,         3'b000, 0, 3'b000);
        add(0, 3'b100, 0, 64'h0,         3'b100, 1, 3'b000);
        add(0, 3'b101, 0, 64'h0,         3'b100, 1, 3'b000);
        add(0, 3'b101, 1, 64'h22,        3'b100, 1, 3'b100);
        add(0, 3'b001, 0, 64'h0,         3'b000, 0, 3'b000);
        add(0, 3'b001, 0, 64'h0,         3'b001, 1, 3'b000);
        add(0, 3'b001, 1, 64'h33,        3'b001, 1, 3'b001);
        add(0, 3'b000, 0, 64'h0,         3'b000, 0, 3'b000);
        // abort by master 1; next winner shows where the pointer sits
        add(0, 3'b010, 0, 64'h0,         3'b000, 0, 3'b000);
        add(0, 3'b010, 0, 64'h0,         3'b010, 1, 3'b000);
        add(0, 3'b000, 0, 64'h0,         3'b010, 0, 3'b000);
        add(0, 3'b111, 0, 64'h0,         3'b000, 0, 3'b000);
        add(0, 3'b111, 0, 64'h0,         AFTER_ABORT, 1, 3'b000);
        add(0, 3'b111, 1, 64'h44,        AFTER_ABORT, 1, AFTER_ABORT);
        // stray response in IDLE, then reset in BUSY with a late response
        add(0, 3'b000, 1, 64'h55,        3'b000, 0, 3'b000);
        add(0, 3'b001, 0, 64'h0,         3'b000, 0, 3'b000);
        add(0, 3'b001, 0, 64'h0,         3'b001, 1, 3'b000);
        add(1, 3'b001, 0, 64'h0,         3'b001, 1, 3'b000);
        add(0, 3'b000, 1, 64'h66,        3'b000, 0, 3'b000);
        add(0, 3'b000, 0, 64'h0,         3'b000, 0, 3'b000);

        @(posedge clk);
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
            #1;
            check($sformatf("row%0d grant", i), 64'(m_grant), 64'(tbl[i].exp_grant));
            check($sformatf("row%0d s_req_valid", i), 64'(s_req_valid), 64'(tbl[i].exp_sreq));
            check($sformatf("row%0d s_req_addr", i), s_req_addr, sel_addr(tbl[i].exp_grant));
            check($sformatf("row%0d s_req_size", i), 64'(s_req_size), 64'(sel_size(tbl[i].exp_grant)));
            check($sformatf("row%0d m_rsp_valid", i), 64'(m_rsp_valid), 64'(tbl[i].exp_rsp));
            check($sformatf("row%0d m_rsp_data", i), m_rsp_data, tbl[i].d);
        end

        // fairness: all masters held valid, bridge answers 2 cycles after each request
        held = 0;
        for (int c = 0; c < 60 && order.size() < 6; c++) begin
            @(negedge clk);
            s = 1'b0;
            if (m_grant != '0) begin
                held++;
                if (held == 1) order.push_back(onehot_idx(m_grant));
                s = (held == 3);
            end else begin
                held = 0;
            end
            drive(1'b0, 3'b111, s, 64'(order.size()));
        end
        check("fair grant count", 64'(order.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < order.size()) begin
                check($sformatf("fair grant %0d", k), 64'(order[k]), 64'(FAIR_ORDER[k]));
            end
        end

        // randomized traffic against the reference model
        @(negedge clk);
        drive(1'b1, '0, 1'b0, 64'h0);
        @(posedge clk);
        mdl_advance(1'b1, '0, 1'b0);
        for (int c = 0; c < 1500; c++) begin
            logic [N-1:0] v;
            logic         r;
            logic         sv;
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                v[k] = ($urandom_range(0, 3) != 0);
                addr_a[k] = {$urandom, $urandom};
                size_a[k] = 2'($urandom_range(0, 3));
            end
            r  = ($urandom_range(0, 63) == 0);
            sv = ($urandom_range(0, 3) == 0);
            drive(r, v, sv, {$urandom, $urandom});
            #1;
            eg = mdl_busy ? N'(1) << mdl_owner : '0;
            check($sformatf("rnd%0d grant", c), 64'(m_grant), 64'(eg));
            check($sformatf("rnd%0d s_req_valid", c), 64'(s_req_valid),
                  64'(mdl_busy && v[mdl_owner]));
            check($sformatf("rnd%0d s_req_addr", c), s_req_addr,
                  mdl_busy ? addr_a[mdl_owner] : 64'h0);
            check($sformatf("rnd%0d s_req_size", c), 64'(s_req_size),
                  64'(mdl_busy ? size_a[mdl_owner] : 2'b00));
            check($sformatf("rnd%0d m_rsp_valid", c), 64'(m_rsp_valid),
                  64'((mdl_busy && sv) ? eg : '0));
            check($sformatf("rnd%0d m_rsp_data", c), m_rsp_data, rsp_data);
            mdl_advance(r, v, sv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
